// File: rtl/alu_instr_sequencer.sv
// Hardwired control-step generator for 3-register ALU instructions.
// Ports: clk, reset, start, mem_ready, ir in; bus/load strobes,
// reg_out_en/reg_in_en one-hot enables, alu_op, busy, done, illegal out.
module alu_instr_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OPCODE_W   = 5,
  parameter int REG_SEL_W  = 4,
  parameter logic [(2**OPCODE_W)-1:0] OP_MASK = 32'h0000_0FFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mem_ready,
  input  logic [DATA_WIDTH-1:0]    ir,
  output logic                     PCout,
  output logic                     Zlowout,
  output logic                     MDRout,
  output logic                     MARin,
  output logic                     Zin,
  output logic                     PCin,
  output logic                     MDRin,
  output logic                     IRin,
  output logic                     Yin,
  output logic                     IncPC,
  output logic                     read,
  output logic [2**REG_SEL_W-1:0]  reg_out_en,
  output logic [2**REG_SEL_W-1:0]  reg_in_en,
  output logic [OPCODE_W-1:0]      alu_op,
  output logic                     busy,
  output logic                     done,
  output logic                     illegal
);

  localparam int LOW_W =
    DATA_WIDTH - OPCODE_W - 3 * REG_SEL_W;
  localparam int RA_HI = DATA_WIDTH - OPCODE_W - 1;
  localparam int RB_HI = RA_HI - REG_SEL_W;
  localparam int RC_HI = RB_HI - REG_SEL_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T1W,
    S_T2,
    S_T3,
    S_T4,
    S_T5
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_SEL_W-1:0] ra;
  logic [REG_SEL_W-1:0] rb;
  logic [REG_SEL_W-1:0] rc;
  logic                 legal;

  assign opcode = ir[DATA_WIDTH-1 -: OPCODE_W];
  assign ra     = ir[RA_HI -: REG_SEL_W];
  assign rb     = ir[RB_HI -: REG_SEL_W];
  assign rc     = ir[RC_HI -: REG_SEL_W];
  assign legal  = OP_MASK[opcode];

  // Low IR bits (immediate/unused fields) play no part in control.
  if (LOW_W > 0) begin : g_low
    logic ir_low_unused;
    assign ir_low_unused = ^ir[LOW_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = mem_ready ? S_T2 : S_T1W;
      S_T1W:  if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = legal ? S_T4 : S_IDLE;
      S_T4:   state_d = S_T5;
      S_T5:   state_d = start ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Moore decode; T3..T5 also look at the IR fields, which are
  // stable once IRin has fired in T2.
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    read       = 1'b0;
    reg_out_en = '0;
    reg_in_en  = '0;
    alu_op     = '0;
    done       = 1'b0;
    illegal    = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        read    = 1'b1;
        MDRin   = 1'b1;
      end
      // Wait state keeps the read alive but must not reload PC.
      S_T1W: begin
        read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (legal) begin
          reg_out_en[rb] = 1'b1;
          Yin            = 1'b1;
        end else begin
          done    = 1'b1;
          illegal = 1'b1;
        end
      end
      S_T4: begin
        reg_out_en[rc] = 1'b1;
        alu_op         = opcode;
        Zin            = 1'b1;
      end
      S_T5: begin
        Zlowout       = 1'b1;
        reg_in_en[ra] = 1'b1;
        done          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
